// File: rtl/note_sequencer_if.sv
// ============================================================================
// Module      : note_sequencer_if
// Description : Table-write, control and note-output bundle of the sequencer.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface note_sequencer_if #(
  parameter int AW = 5
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [6:0]    wr_note;
  logic [7:0]    wr_dur;
  logic [AW:0]   seq_len;
  logic          start;
  logic          stop;
  logic          loop;
  logic [6:0]    note_code;
  logic          playing;
  logic [AW-1:0] step;
  logic          done;

  modport master (
    output wr_en, wr_addr, wr_note, wr_dur, seq_len, start, stop, loop,
    input  note_code, playing, step, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_note, wr_dur, seq_len, start, stop, loop,
    output note_code, playing, step, done
  );
endinterface

`default_nettype wire

// File: rtl/note_sequencer.sv
// ============================================================================
// Module      : note_sequencer
// Description : Table-driven melody sequencer feeding the note generator.
//               Optional inter-note rest enabled by macro NOTE_SEQ_GAP_EN.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module note_sequencer #(
  parameter int         DEPTH     = 32,
  parameter int         AW        = 5,
  parameter int         TICK_DIV  = 500000,
  parameter logic [6:0] REST_CODE = 7'd127,
  parameter int         GAP_TICKS = 1
) (
  input  wire             clk,
  input  wire             reset_n,
  note_sequencer_if.slave bus
);

  localparam int          c_TW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_PLAY = 3'd2,
`ifdef NOTE_SEQ_GAP_EN
    S_GAP  = 3'd3,
`endif
    S_FIN  = 3'd4
  } state_t;

  state_t          r_state;
  logic [6:0]      r_note;
  logic            r_playing;
  logic [AW-1:0]   r_step;
  logic            r_done;
  logic [c_TW-1:0] r_tick;
  logic [7:0]      r_dur;
  logic [14:0]     r_mem [DEPTH];

  logic [AW:0]     w_len;
  logic            w_more;
  logic            w_tick_wrap;
  logic [6:0]      w_rd_note;
  logic [7:0]      w_rd_dur;
  state_t          w_adv_state;
  logic [AW-1:0]   w_adv_step;

  // Table has no reset; a read in LOAD sees the pre-edge contents.
  always_ff @(posedge clk) begin
    if (bus.wr_en) begin
      r_mem[bus.wr_addr] <= {bus.wr_note, bus.wr_dur};
    end
  end

  assign {w_rd_note, w_rd_dur} = r_mem[r_step];
  assign w_len       = (bus.seq_len > c_DEPTH) ? c_DEPTH : bus.seq_len;
  assign w_more      = ({1'b0, r_step} + (AW+1)'(1)) < w_len;
  assign w_tick_wrap = (r_tick == c_TW'(TICK_DIV - 1));

  // Where to go once the current note (and any gap) has finished.
  always_comb begin
    w_adv_state = S_FIN;
    w_adv_step  = r_step;
    if (w_more) begin
      w_adv_state = S_LOAD;
      w_adv_step  = r_step + AW'(1);
    end else if (bus.loop) begin
      w_adv_state = S_LOAD;
      w_adv_step  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_note    <= REST_CODE;
      r_playing <= 1'b0;
      r_step    <= '0;
      r_done    <= 1'b0;
      r_tick    <= '0;
      r_dur     <= '0;
    end else begin
      r_done <= 1'b0;
      if (bus.stop) begin
        r_state   <= S_IDLE;
        r_note    <= REST_CODE;
        r_playing <= 1'b0;
        r_step    <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_note    <= REST_CODE;
            r_playing <= 1'b0;
            if (bus.start && (w_len != '0)) begin
              r_step  <= '0;
              r_state <= S_LOAD;
            end
          end
          S_LOAD: begin
            if (w_rd_dur == 8'd0) begin
              r_done    <= 1'b1;
              r_note    <= REST_CODE;
              r_playing <= 1'b0;
              r_step    <= '0;
              r_state   <= S_IDLE;
            end else begin
              r_note    <= w_rd_note;
              r_dur     <= w_rd_dur;
              r_tick    <= '0;
              r_playing <= 1'b1;
              r_state   <= S_PLAY;
            end
          end
          S_PLAY: begin
            if (w_tick_wrap) begin
              r_tick <= '0;
              r_dur  <= r_dur - 8'd1;
              if (r_dur == 8'd1) begin
`ifdef NOTE_SEQ_GAP_EN
                if (GAP_TICKS == 0) begin
                  r_state <= w_adv_state;
                  r_step  <= w_adv_step;
                end else begin
                  r_note  <= REST_CODE;
                  r_dur   <= 8'(GAP_TICKS);
                  r_state <= S_GAP;
                end
`else
                r_state <= w_adv_state;
                r_step  <= w_adv_step;
`endif
              end
            end else begin
              r_tick <= r_tick + c_TW'(1);
            end
          end
`ifdef NOTE_SEQ_GAP_EN
          S_GAP: begin
            if (w_tick_wrap) begin
              r_tick <= '0;
              r_dur  <= r_dur - 8'd1;
              if (r_dur == 8'd1) begin
                r_state <= w_adv_state;
                r_step  <= w_adv_step;
              end
            end else begin
              r_tick <= r_tick + c_TW'(1);
            end
          end
`endif
          // Last note holds one extra cycle, matching the LOAD slot of a successor.
          S_FIN: begin
            r_done    <= 1'b1;
            r_note    <= REST_CODE;
            r_playing <= 1'b0;
            r_step    <= '0;
            r_state   <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.note_code = r_note;
  assign bus.playing   = r_playing;
  assign bus.step      = r_step;
  assign bus.done      = r_done;

endmodule

`default_nettype wire
